bf_stdout_uart_tx: RTL and testbench
====================================

Name: bf_stdout_uart_tx

Overview:
Downstream consumer of the brainfuck core's output port. Captures each byte presented with a one-cycle stdout_en pulse into a small FIFO. Serialises the bytes onto a UART TX line as 8N1 frames. Decouples the core's burst output rate from the slow serial line and flags any dropped bytes.

Parameters:
CLK_DIV, 16, clock cycles per UART bit (legal range 2..65535)
FIFO_AW, 4, log2 of FIFO depth (depth = 2**FIFO_AW)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_data  in  8  byte to transmit; connects to core stdout
in_valid  in  1  one-cycle write strobe; connects to core stdout_en
tx  out  1  UART serial output; idle high
busy  out  1  high while a frame is in progress or the FIFO is non-empty
fifo_full  out  1  FIFO holds 2**FIFO_AW entries
fifo_level  out  FIFO_AW+1  current FIFO occupancy
overflow  out  1  sticky; set when a byte is dropped

Behaviour:
- Reset (synchronous, active-high, applied on clk edge):
  - tx=1, busy=0, fifo_full=0, fifo_level=0, overflow=0.
  - FIFO is emptied, FSM goes to IDLE, and the bit and baud counters clear.
  - Reset mid-frame aborts the frame: tx is high from the edge after reset is sampled, and no partial stop bit is sent.
- Push:
  - in_valid sampled high while the FIFO is not full writes in_data.
  - A push while full is accepted only if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1. It stays 1 until reset.
  - in_valid held high for N cycles pushes N bytes; the block does not detect edges.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, go to START and drive tx=0, all on the same edge.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. On the last STOP cycle:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames with no idle gap);
    - otherwise go to IDLE.
- Latency: for a byte pushed at edge E into an empty FIFO with the FSM in IDLE, tx falls at edge E+1.
- Frame length is exactly 10*CLK_DIV cycles; back-to-back frames have period 10*CLK_DIV.
- Baud counter: counts 0..CLK_DIV-1 and is reloaded to 0 on every state or bit transition.
- fifo_level / fifo_full update on the edge of the push/pop. A simultaneous push and pop leaves the level unchanged.
- busy = (state != IDLE) || (fifo_level != 0). busy is registered-consistent: no combinational path from in_valid.
- All outputs are registered except busy and fifo_full, which decode from registers only.

Decomposition:
- Package bf_uart_pkg:
  - FSM state encoding (2-bit enum IDLE/START/DATA/STOP);
  - UART constants: DATA_BITS=8, STOP_BITS=1, IDLE_LEVEL=1.
- Sub-module bf_sync_fifo:
  - parameterised width/depth, single clock, synchronous reset;
  - ports: push, pop, wdata, rdata (head, first-word-fall-through), full, empty, level;
  - wrap-around pointers FIFO_AW+1 bits wide, with the MSB distinguishing full from empty.
- Top level holds the FSM, baud counter, shift register and overflow flag.

Test Plan:
- Single byte, CLK_DIV=4: push 0x48 at edge E.
  - tx falls at E+1 and stays low 4 cycles.
  - Then bits 0,0,0,1,0,0,1,0, 4 cycles each, then high 4 cycles.
  - busy drops at the edge ending the stop bit.
- Back-to-back, CLK_DIV=4: push "H","i" on consecutive cycles.
  - Two frames, 40 cycles each, contiguous: the 'i' start bit begins immediately after the 'H' stop bit.
  - fifo_level sequence 1,1,0 (push/pop overlap on the second push), then 0.
- Overflow, FIFO_AW=2, CLK_DIV=16: push 6 bytes 0x01..0x06 on consecutive cycles.
  - Byte 1 is popped immediately; bytes 2–5 fill the FIFO.
  - Byte 6 is dropped and overflow=1.
  - The line carries 0x01..0x05 only.
- Full plus simultaneous pop, FIFO_AW=2, CLK_DIV=4:
  - Fill to 4 entries while a frame is in progress.
  - Present a push on the exact cycle the FSM pops at end of STOP.
  - Push is accepted, fifo_level stays 4, overflow stays 0.
- Reset mid-frame: assert reset for one cycle during DATA bit 3 of 0xA5, with 2 more bytes queued.
  - Next cycle: tx=1, busy=0, fifo_level=0, overflow=0.
  - No further frames are sent.
- Core integration: drive from the processor running "++++++++[>++++++++<-]>+." (ASCII 'A').
  - Exactly one frame decoding to 0x41 appears on tx; overflow=0.

Source files
------------

// File: rtl/bf_uart_pkg.sv
// rtl/bf_uart_pkg.sv - shared FSM encoding and 8N1 line constants for the stdout UART
package bf_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bf_sync_fifo.sv
// rtl/bf_sync_fifo.sv - single-clock first-word-fall-through FIFO with wrap-bit pointers
module bf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the write side lapped the read side.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/bf_stdout_uart_tx.sv
// rtl/bf_stdout_uart_tx.sv - buffers core stdout bytes and sends them as 8N1 UART frames
module bf_stdout_uart_tx
    import bf_uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               tx,
    output logic               busy,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  head;
    logic        fifo_empty;
    logic        baud_last;
    logic        pop;
    logic        push;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Head leaves the FIFO either from IDLE or on the final STOP cycle (back-to-back).
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
    assign push = in_valid && (!fifo_full || pop);

    assign busy = (state != IDLE) || (fifo_level != '0);

    bf_sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Sticky drop flag: a write strobe that the FIFO could not absorb.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_valid && !push) begin
            overflow <= 1'b1;
        end
    end

    // Frame sequencer: tx is registered so a reset edge returns the line high at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= IDLE_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= IDLE_LEVEL;
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shift <= head;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift <= head;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= IDLE_LEVEL;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx       <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_stdout_uart_tx.sv
// tb/tb_bf_stdout_uart_tx.sv - randomized and directed bench against a frame-timeline model
module tb_bf_stdout_uart_tx;

    localparam int D     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * D;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          tx;
    logic          busy;
    logic          fifo_full;
    logic [AW:0]   fifo_level;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    bf_stdout_uart_tx #(
        .CLK_DIV (D),
        .FIFO_AW (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Model: queue of waiting bytes, the byte on the wire, and position t within its frame.
    int mq[$];
    int done_q[$];
    int rx_q[$];
    int cur  = 0;
    int t    = -1;
    bit movf = 1'b0;

    always @(posedge clk) begin
        bit pop;
        bit was_full;
        if (t == FLEN - 1) done_q.push_back(cur);
        if (reset) begin
            mq.delete();
            t    = -1;
            movf = 1'b0;
        end else begin
            pop      = (mq.size() > 0) && (t < 0 || t == FLEN - 1);
            was_full = (mq.size() == DEPTH);
            if (pop) begin
                cur = mq.pop_front();
                t   = 0;
            end else if (t == FLEN - 1) begin
                t = -1;
            end else if (t >= 0) begin
                t++;
            end
            if (in_valid) begin
                if (!was_full || pop) mq.push_back(int'(in_data));
                else movf = 1'b1;
            end
        end
    end

    function automatic int exp_tx();
        int k;
        if (t < 0) return 1;
        k = t / D;
        if (k == 0) return 0;
        if (k == 9) return 1;
        return (cur >> (k - 1)) & 1;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Line decoder: samples mid-bit on falling clock edges, independent of the model.
    int dcnt = -1;
    logic [7:0] dsh = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            dcnt = -1;
        end else if (dcnt < 0) begin
            if (tx == 1'b0) dcnt = 0;
        end else begin
            dcnt++;
            if ((dcnt % D) == D / 2 && dcnt / D >= 1 && dcnt / D <= 8) dsh[dcnt / D - 1] = tx;
            if (dcnt == 9 * D + D / 2) check_eq("stop_bit", int'(tx), 1);
            if (dcnt == FLEN - 1) begin
                rx_q.push_back(int'(dsh));
                dcnt = -1;
            end
        end
    end

    task automatic tick_check();
        @(negedge clk);
        check_eq("tx", int'(tx), exp_tx());
        check_eq("level", int'(fifo_level), mq.size());
        check_eq("full", int'(fifo_full), int'(mq.size() == DEPTH));
        check_eq("busy", int'(busy), int'(t >= 0 || mq.size() > 0));
        check_eq("overflow", int'(overflow), int'(movf));
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        #1;
        in_valid = v;
        in_data  = d;
        reset    = r;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        tick_check();
        drive(v, d, r);
    endtask

    task automatic cmp_frames();
        int n;
        check_eq("nframes", rx_q.size(), done_q.size());
        n = (rx_q.size() < done_q.size()) ? rx_q.size() : done_q.size();
        for (int i = 0; i < n; i++) check_eq("frame_byte", rx_q[i], done_q[i]);
        rx_q.delete();
        done_q.delete();
    endtask

    task automatic drain();
        int n = 0;
        while ((t >= 0 || mq.size() > 0) && n < 2000) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        check_eq("drain_bound", int'(n < 2000), 1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        cmp_frames();
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        rx_q.delete();
        done_q.delete();
    endtask

    task automatic run_bf(input string prog);
        byte unsigned tape[16];
        int p = 0;
        int pc = 0;
        int guard = 0;
        int depth;
        for (int i = 0; i < 16; i++) tape[i] = 0;
        while (pc < prog.len() && guard < 5000) begin
            case (prog[pc])
                "+": tape[p] = tape[p] + 1;
                "-": tape[p] = tape[p] - 1;
                ">": p = (p + 1) % 16;
                "<": p = (p + 15) % 16;
                "[": if (tape[p] == 0) begin
                        depth = 1;
                        while (depth > 0) begin
                            pc++;
                            if (prog[pc] == "[") depth++;
                            else if (prog[pc] == "]") depth--;
                        end
                     end
                "]": if (tape[p] != 0) begin
                        depth = 1;
                        while (depth > 0) begin
                            pc--;
                            if (prog[pc] == "]") depth++;
                            else if (prog[pc] == "[") depth--;
                        end
                     end
                default: ;
            endcase
            if (prog[pc] == ".") step(1'b1, tape[p], 1'b0);
            else step(1'b0, 8'h00, 1'b0);
            pc++;
            guard++;
        end
        check_eq("bf_guard", int'(guard < 5000), 1);
    endtask

    initial begin
        int n;
        // Reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        tick_check();
        check_eq("rst_tx", int'(tx), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_full", int'(fifo_full), 0);
        check_eq("rst_level", int'(fifo_level), 0);
        check_eq("rst_ovf", int'(overflow), 0);
        drive(1'b0, 8'h00, 1'b0);

        // Single byte 0x48: tx must fall one edge after the push edge
        step(1'b1, 8'h48, 1'b0);
        tick_check();
        check_eq("lat_tx_hi", int'(tx), 1);
        check_eq("lat_level", int'(fifo_level), 1);
        drive(1'b0, 8'h00, 1'b0);
        tick_check();
        check_eq("lat_tx_lo", int'(tx), 0);
        drive(1'b0, 8'h00, 1'b0);
        drain();

        // Back-to-back "H","i"
        step(1'b1, 8'h48, 1'b0);
        step(1'b1, 8'h69, 1'b0);
        tick_check();
        check_eq("b2b_level1", int'(fifo_level), 1);
        drive(1'b0, 8'h00, 1'b0);
        tick_check();
        check_eq("b2b_level2", int'(fifo_level), 1);
        drive(1'b0, 8'h00, 1'b0);
        drain();

        // Overflow: six consecutive pushes into a 4-deep FIFO
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_eq("ovf_set", int'(overflow), 1);
        check_eq("ovf_full", int'(fifo_full), 1);
        drain();
        check_eq("ovf_sticky", int'(overflow), 1);

        // Full FIFO with a push on the exact STOP-end pop edge
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        n = 0;
        forever begin
            tick_check();
            if (t == FLEN - 1 || n > 200) break;
            drive(1'b0, 8'h00, 1'b0);
            n++;
        end
        check_eq("fp_found", int'(n <= 200), 1);
        drive(1'b1, 8'hEE, 1'b0);
        tick_check();
        check_eq("fp_level", int'(fifo_level), 4);
        check_eq("fp_ovf", int'(overflow), 0);
        drive(1'b0, 8'h00, 1'b0);
        drain();

        // Reset during data bit 3 of 0xA5 with two bytes queued
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'hB1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        n = 0;
        forever begin
            tick_check();
            if (t == 4 * D + 1 || n > 200) break;
            drive(1'b0, 8'h00, 1'b0);
            n++;
        end
        check_eq("mr_found", int'(n <= 200), 1);
        drive(1'b0, 8'h00, 1'b1);
        tick_check();
        check_eq("mr_tx", int'(tx), 1);
        check_eq("mr_busy", int'(busy), 0);
        check_eq("mr_level", int'(fifo_level), 0);
        check_eq("mr_ovf", int'(overflow), 0);
        drive(1'b0, 8'h00, 1'b0);
        repeat (3 * FLEN) step(1'b0, 8'h00, 1'b0);
        check_eq("mr_no_frames", rx_q.size(), 0);
        cmp_frames();

        // Core integration: program prints 'A'
        do_reset();
        run_bf("++++++++[>++++++++<-]>+.");
        drain();
        check_eq("bf_ovf", int'(overflow), 0);

        // Randomized bursts with occasional resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 99) < 12), 8'($urandom), 1'($urandom_range(0, 399) == 0));
        end
        step(1'b0, 8'h00, 1'b0);
        drain();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'b0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
